fir_postnorm_pack: RTL and testbench



---
 rtl/fir_fp_pkg.sv | 43 ++++
 rtl/fir_postnorm_pack_if.sv | 30 +++
 rtl/fir_lzc.sv | 20 ++
 rtl/fir_postnorm_pack.sv | 157 +++++++++++++++
 tb/tb_fir_postnorm_pack.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fir_fp_pkg.sv
// Shared floating-point definitions for the FIR datapath.
//   - IEEE-754 single constants and packed-word field offsets
//   - stage-1 payload struct handed from normalize to round/pack
//   - fp_pack helper that assembles a packed single from its fields
package fir_fp_pkg;

    localparam int FP_BIAS     = 127;
    localparam int FP_EXP_MAX  = 255;
    localparam int FRAC_W      = 23;
    localparam int SIG_W       = FRAC_W + 1;

    // Packed single layout: {sign, exp[7:0], frac[22:0]}
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_EXP_W    = 8;
    localparam int FP_FRAC_LSB = 0;

    // Incoming biased exponent width and the one-bit-wider adjusted exponent
    // carried between the stages (room for the normalization shift).
    localparam int FP_EXP_IN_W = 10;
    localparam int S1_EXP_W    = FP_EXP_IN_W + 1;

    typedef struct packed {
        logic                       sign;
        logic signed [S1_EXP_W-1:0] exp;
        logic [SIG_W-1:0]           sig;
        logic                       guard;
        logic                       sticky;
        logic                       zero;
    } s1_payload_t;

    function automatic logic [31:0] fp_pack(input logic s,
                                            input logic [FP_EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
        logic [31:0] r;
        r = '0;
        r[FP_SIGN_BIT]               = s;
        r[FP_EXP_LSB +: FP_EXP_W]    = e;
        r[FP_FRAC_LSB +: FRAC_W]     = f;
        return r;
    endfunction

endpackage

// File: rtl/fir_postnorm_pack_if.sv
// Handshake bundle for the post-normalize/pack stage.
//   in side : in_valid/in_ready, sign_in, exp_in, mant_in
//   out side: out_valid/out_ready, out_data, out_overflow/underflow/inexact
// master = producer/consumer around the block, slave = the block itself.
interface fir_postnorm_pack_if #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_overflow;
    logic              out_underflow;
    logic              out_inexact;

    modport master (
        output in_valid, sign_in, exp_in, mant_in, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_underflow, out_inexact
    );
endinterface

// File: rtl/fir_lzc.sv
// Parameterized leading-zero counter.
//   din   : W-bit vector
//   count : number of zeros above the most significant one (W when din==0)
module fir_lzc #(
    parameter int W     = 48,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count
);

    // Scanning upward lets the highest set bit overwrite the result last.
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) count = CNT_W'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fir_postnorm_pack.sv
// Post-normalization, round-to-nearest-even and IEEE single pack.
// Two-stage valid/ready pipeline: stage 1 normalizes, stage 2 rounds/packs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fir_postnorm_pack_if.slave (input beat, packed result + flags)
// Optional build macro FIR_POSTNORM_SUBNORM_EN: produce subnormal results
// instead of flushing exponents <= 0 to zero.
module fir_postnorm_pack
    import fir_fp_pkg::*;
#(
    parameter int MANT_W = 48,
    parameter int EXP_W  = FP_EXP_IN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_postnorm_pack_if.slave  bus
);

    localparam int LZ_W = $clog2(MANT_W + 1);
    localparam logic signed [S1_EXP_W-1:0] EXP_ONE  = S1_EXP_W'(1);
    localparam logic signed [S1_EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [S1_EXP_W-1:0] EXP_TOP  = S1_EXP_W'(FP_EXP_MAX);

    logic                       s1_valid;
    logic                       s1_adv;
    logic                       in_fire;
    s1_payload_t                s1_next;
    s1_payload_t                s1_q;
    logic [LZ_W-1:0]            lz;
    logic [MANT_W-1:0]          norm;
    logic signed [S1_EXP_W-1:0] exp_ext;

    logic                       out_valid_q;
    logic [31:0]                out_data_q;
    logic                       ovf_q, unf_q, inx_q;

    logic                       inc;
    logic [SIG_W:0]             sum;
    logic signed [S1_EXP_W-1:0] exp_f;
    logic [31:0]                pk_data;
    logic                       pk_ovf, pk_unf, pk_inx;

    assign s1_adv       = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;

    fir_lzc #(.W(MANT_W)) u_lzc (
        .din   (bus.mant_in),
        .count (lz)
    );

    // Shifting left by the zero count puts the leading one at the MSB; the
    // exponent moves by (1 - lz) because the 1.0 position sits one bit
    // below the MSB. This covers the right-shift case (lz == 0) too.
    always_comb begin
        exp_ext        = S1_EXP_W'($signed(bus.exp_in));
        s1_next.sign   = bus.sign_in;
        s1_next.zero   = (bus.mant_in == '0);
        norm           = s1_next.zero ? '0 : (bus.mant_in << lz);
        s1_next.exp    = exp_ext + EXP_ONE - $signed(S1_EXP_W'(lz));
        s1_next.sig    = norm[MANT_W-1 -: SIG_W];
        s1_next.guard  = norm[MANT_W-1-SIG_W];
        s1_next.sticky = |norm[MANT_W-2-SIG_W:0];
    end

    // Stage 1 register: loads on input handshake, empties when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_next;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

`ifdef FIR_POSTNORM_SUBNORM_EN
    logic signed [S1_EXP_W-1:0] sub_sh;
    logic [4:0]                 sub_amt;
    logic [SIG_W+26:0]          sub_vec;
    logic [SIG_W-1:0]           sub_sig;
    logic                       sub_g, sub_st, sub_inc;
    logic [SIG_W-1:0]           sub_sum;

    // Denormalize by (1 - exp) before rounding. Beyond 26 positions every
    // significand bit already lands in sticky, so the shift is clamped.
    always_comb begin
        sub_sh  = EXP_ONE - s1_q.exp;
        sub_amt = (sub_sh > S1_EXP_W'(26)) ? 5'd26 : sub_sh[4:0];
        sub_vec = {s1_q.sig, s1_q.guard, 26'b0} >> sub_amt;
        sub_sig = sub_vec[SIG_W+26:27];
        sub_g   = sub_vec[26];
        sub_st  = s1_q.sticky | (|sub_vec[25:0]);
        sub_inc = sub_g & (sub_st | sub_sig[0]);
        sub_sum = sub_sig + SIG_W'(sub_inc);
    end
`endif

    // Round to nearest even, renormalize on carry, then classify the result.
    always_comb begin
        inc     = s1_q.guard & (s1_q.sticky | s1_q.sig[0]);
        sum     = {1'b0, s1_q.sig} + (SIG_W+1)'(inc);
        exp_f   = s1_q.exp + (sum[SIG_W] ? EXP_ONE : EXP_ZERO);
        pk_data = fp_pack(s1_q.sign, exp_f[FP_EXP_W-1:0],
                          sum[SIG_W] ? sum[SIG_W-1:1] : sum[SIG_W-2:0]);
        pk_ovf  = 1'b0;
        pk_unf  = 1'b0;
        pk_inx  = s1_q.guard | s1_q.sticky;
        if (s1_q.zero) begin
            pk_data = fp_pack(s1_q.sign, '0, '0);
            pk_inx  = 1'b0;
        end else if (exp_f >= EXP_TOP) begin
            pk_data = fp_pack(s1_q.sign, '1, '0);
            pk_ovf  = 1'b1;
            pk_inx  = 1'b1;
`ifdef FIR_POSTNORM_SUBNORM_EN
        end else if (s1_q.exp <= EXP_ZERO) begin
            // A carry into the hidden bit promotes the result to exp field 1.
            pk_data = fp_pack(s1_q.sign, {7'b0, sub_sum[SIG_W-1]}, sub_sum[SIG_W-2:0]);
            pk_inx  = sub_g | sub_st;
            pk_unf  = sub_g | sub_st;
`else
        end else if (exp_f <= EXP_ZERO) begin
            pk_data = fp_pack(s1_q.sign, '0, '0);
            pk_unf  = 1'b1;
            pk_inx  = 1'b1;
`endif
        end
    end

    // Output register: holds while downstream stalls, clears after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pk_data;
            ovf_q       <= pk_ovf;
            unf_q       <= pk_unf;
            inx_q       <= pk_inx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_inexact   = inx_q;

endmodule

// File: tb/tb_fir_postnorm_pack.sv
// Directed testbench for fir_postnorm_pack: single vectors at latency 2,
// rounding/overflow/underflow boundaries, backpressure and mid-stream reset.
// Expected underflow results follow the FIR_POSTNORM_SUBNORM_EN build setting.
module tb_fir_postnorm_pack;
    import fir_fp_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fir_postnorm_pack_if #(.MANT_W(48), .EXP_W(10)) bus ();

    fir_postnorm_pack #(.MANT_W(48), .EXP_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [47:0] m);
        bus.in_valid = 1'b1;
        bus.sign_in  = s;
        bus.exp_in   = e;
        bus.mant_in  = m;
    endtask

    function automatic logic [31:0] flagsNow();
        return {29'b0, bus.out_overflow, bus.out_underflow, bus.out_inexact};
    endfunction

    // One beat into an empty pipeline; result must appear exactly two edges later.
    task automatic runVector(input string tag, input logic s, input logic [9:0] e,
                             input logic [47:0] m, input logic [31:0] want_data,
                             input logic [2:0] want_flags);
        applyStimulus(s, e, m);
        #1;
        checkOutput({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_data"}, bus.out_data, want_data);
        checkOutput({tag, "_flags"}, flagsNow(), 32'(want_flags));
        @(posedge clk); #1;
    endtask

    logic [47:0] bp_m [5];
    logic [9:0]  bp_e [5];
    logic        bp_s [5];
    logic [31:0] bp_x [5];

    initial begin
        int idx;
        int got_n;
        logic in_hs;
        logic out_hs;

        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.mant_in   = '0;
        bus.out_ready = 1'b1;

        #2;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", bus.out_data, 32'h0);
        checkOutput("rst_flags", flagsNow(), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        runVector("one",     1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000);
        runVector("rshift",  1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 3'b000);
        runVector("ovf",     1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 3'b101);
        runVector("maxnorm", 1'b0, 10'd254, 48'h4000_0000_0000, 32'h7F00_0000, 3'b000);
        runVector("tie",     1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001);
        runVector("rup",     1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001);
        runVector("carry",   1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 32'h4000_0000, 3'b001);
        runVector("tiny",    1'b0, 10'd127, 48'h0000_0000_0001, 32'h2880_0000, 3'b000);
        runVector("negzero", 1'b1, 10'd127, 48'h0000_0000_0000, 32'h8000_0000, 3'b000);
        runVector("negone",  1'b1, 10'd127, 48'h4000_0000_0000, 32'hBF80_0000, 3'b000);
        runVector("minnorm", 1'b0, 10'd1,   48'h4000_0000_0000, 32'h0080_0000, 3'b000);
`ifdef FIR_POSTNORM_SUBNORM_EN
        runVector("unf0",    1'b0, 10'd0,   48'h4000_0000_0000, 32'h0040_0000, 3'b000);
        runVector("unfinx",  1'b0, 10'd0,   48'h4000_0000_0001, 32'h0040_0000, 3'b011);
        runVector("unfneg",  1'b0, 10'h3FB, 48'h4000_0000_0000, 32'h0002_0000, 3'b000);
`else
        runVector("unf0",    1'b0, 10'd0,   48'h4000_0000_0000, 32'h0000_0000, 3'b011);
        runVector("unfinx",  1'b0, 10'd0,   48'h4000_0000_0001, 32'h0000_0000, 3'b011);
        runVector("unfneg",  1'b0, 10'h3FB, 48'h4000_0000_0000, 32'h0000_0000, 3'b011);
`endif

        // Backpressure: five beats offered back-to-back, out_ready low 4 cycles.
        bp_s[0] = 1'b0; bp_e[0] = 10'd127; bp_m[0] = 48'h4000_0000_0000; bp_x[0] = 32'h3F80_0000;
        bp_s[1] = 1'b0; bp_e[1] = 10'd127; bp_m[1] = 48'h8000_0000_0000; bp_x[1] = 32'h4000_0000;
        bp_s[2] = 1'b0; bp_e[2] = 10'd127; bp_m[2] = 48'h0000_0000_0001; bp_x[2] = 32'h2880_0000;
        bp_s[3] = 1'b1; bp_e[3] = 10'd127; bp_m[3] = 48'h4000_0000_0000; bp_x[3] = 32'hBF80_0000;
        bp_s[4] = 1'b0; bp_e[4] = 10'd127; bp_m[4] = 48'h4000_00C0_0000; bp_x[4] = 32'h3F80_0002;

        idx   = 0;
        got_n = 0;
        for (int c = 0; c < 40 && got_n < 5; c++) begin
            bus.out_ready = (c >= 4);
            if (idx < 5) applyStimulus(bp_s[idx], bp_e[idx], bp_m[idx]);
            else bus.in_valid = 1'b0;
            #1;
            if (c == 2 || c == 3) begin
                checkOutput($sformatf("bp_in_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
                checkOutput($sformatf("bp_accepted_c%0d", c), 32'(idx), 32'd2);
                checkOutput($sformatf("bp_hold_c%0d", c), bus.out_data, bp_x[0]);
            end
            in_hs  = bus.in_valid && bus.in_ready;
            out_hs = bus.out_valid && bus.out_ready;
            if (out_hs) begin
                checkOutput($sformatf("bp_out%0d", got_n), bus.out_data, bp_x[got_n]);
                got_n++;
            end
            if (in_hs) idx++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("bp_count", 32'(got_n), 32'd5);
        #1;
        checkOutput("bp_no_dup", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset with two beats in flight: output clears at once, nothing leaks.
        applyStimulus(1'b0, 10'd127, 48'h4000_0000_0000);
        @(posedge clk); #1;
        applyStimulus(1'b0, 10'd127, 48'h4000_00C0_0000);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mrst_out_data", bus.out_data, 32'h0);
        checkOutput("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("mrst_idle1", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("mrst_idle2", 32'(bus.out_valid), 32'd0);
        runVector("post_rst", 1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
